mul_share_arbiter: RTL and testbench
====================================

// Module: mul_share_arbiter
// PURPOSE
//  Shares one combinational multi-limb multiplier (NUM_ELEMENTS limbs x BIT_LEN bits, 2*NUM_ELEMENTS result limbs)
//  among NUM_REQ requesters. Round-robin arbitration; operands are registered into the multiplier and held for
//  MUL_LATENCY cycles (multicycle path). The limb product is captured and returned with the requester ID.
//  Sits between client engines and the multiplier instance; one operation in flight at a time.
// PARAMETERS
//  NUM_REQ       4   number of requesters (>=2)
//  NUM_ELEMENTS  17  operand limbs per multiplier input
//  BIT_LEN       17  bits per limb
//  MUL_LATENCY   2   cycles operands are held before capturing mul_M (>=1)
//  ID_W          $clog2(NUM_REQ)  width of rsp_id (localparam)
// PORTS
//  clk        in   1                             clock
//  rst        in   1                             synchronous reset, active-high
//  req_valid  in   [NUM_REQ]                     requester i has an operation pending
//  req_ready  out  [NUM_REQ]                     one-hot grant/accept, i only
//  req_A      in   [NUM_REQ][NUM_ELEMENTS][BIT_LEN]  operand A limbs per requester
//  req_B      in   [NUM_REQ][NUM_ELEMENTS][BIT_LEN]  operand B limbs per requester
//  mul_A      out  [NUM_ELEMENTS][BIT_LEN]       registered operand A to multiplier
//  mul_B      out  [NUM_ELEMENTS][BIT_LEN]       registered operand B to multiplier
//  mul_M      in   [2*NUM_ELEMENTS][BIT_LEN]     multiplier result limbs
//  rsp_valid  out  1                             result available
//  rsp_ready  in   1                             consumer accepts result
//  rsp_id     out  ID_W                          index of requester owning rsp_M
//  rsp_M      out  [2*NUM_ELEMENTS][BIT_LEN]     captured result limbs
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, wait counter=0, mul_A/mul_B=0, rsp_M=0, rsp_id=0, rsp_valid=0, req_ready=0.
//  States: IDLE -> WAIT -> RESP -> IDLE. Reset in any state returns to IDLE; in-flight op discarded, no response.
//  IDLE: grant g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   req_ready = one-hot(g) combinationally, only in IDLE and only if some req_valid; else all zero.
//   Accept edge (req_valid[g]&req_ready[g]): mul_A<=req_A[g], mul_B<=req_B[g], rsp_id<=g,
//   rr_ptr<=(g+1) mod NUM_REQ, cnt<=MUL_LATENCY-1, state<=WAIT.
//   req_ready is a grant, not a commitment; requester may drop req_valid; grant then recomputes.
//  WAIT: req_ready=0. mul_A/mul_B held stable. At edge with cnt==0: rsp_M<=mul_M, state<=RESP; else cnt--.
//   Latency: accept at edge E0 -> rsp_valid high after edge E0+MUL_LATENCY.
//  RESP: rsp_valid=1; rsp_M, rsp_id stable until handshake. On rsp_valid&rsp_ready edge: state<=IDLE, rsp_valid<=0.
//   No new accept in RESP; earliest next accept is the edge after return to IDLE (IDLE cycle combinational grant).
//   Throughput: one op per MUL_LATENCY+2 cycles with rsp_ready held high.
//  mul_A/mul_B keep last operands in IDLE/RESP (no toggling to zero).
//  Widths: pure pass-through; no arithmetic on limbs. rr_ptr wraps NUM_REQ-1 -> 0.
//  req_A/req_B of non-granted requesters ignored; rsp_ready outside RESP ignored.
// TESTING
//  1 Single op: req_valid=0001, A limbs {0..}={3}, B={5}, MUL_LATENCY=2 -> req_ready=0001 at cycle 0, rsp_valid
//    after 2 edges, rsp_id=0, rsp_M[0]=15, other limbs 0.
//  2 Round-robin: all req_valid=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; each op 4 cycles apart.
//  3 Fairness after skip: rr_ptr=2, req_valid=1001 -> grant 3, then rr_ptr=0 -> grant 0.
//  4 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_M, rsp_id stable; req_ready=0000 throughout.
//  5 Reset mid-op: rst=1 in WAIT -> next cycle state IDLE, rsp_valid=0, rr_ptr=0, no response emitted.
//  6 Max operands: all limbs 2^BIT_LEN-1 via reference model -> rsp_M equals golden limb product; mul_A stable
//    through every WAIT cycle (assertion).

Source files
------------

// File: rtl/mul_share_arbiter_if.sv
// Bundle of requester, multiplier and response signals for the shared multiplier arbiter.
// The slave view belongs to the arbiter; the master view to whatever surrounds it.
interface mul_share_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_ELEMENTS = 17,
    parameter int BIT_LEN      = 17
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                                req_valid;
    logic [NUM_REQ-1:0]                                req_ready;
    logic [NUM_REQ-1:0][NUM_ELEMENTS-1:0][BIT_LEN-1:0] req_A;
    logic [NUM_REQ-1:0][NUM_ELEMENTS-1:0][BIT_LEN-1:0] req_B;
    logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]              mul_A;
    logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]              mul_B;
    logic [2*NUM_ELEMENTS-1:0][BIT_LEN-1:0]            mul_M;
    logic                                              rsp_valid;
    logic                                              rsp_ready;
    logic [ID_W-1:0]                                   rsp_id;
    logic [2*NUM_ELEMENTS-1:0][BIT_LEN-1:0]            rsp_M;

    modport slave (
        input  req_valid, req_A, req_B, mul_M, rsp_ready,
        output req_ready, mul_A, mul_B, rsp_valid, rsp_id, rsp_M
    );

    modport master (
        output req_valid, req_A, req_B, mul_M, rsp_ready,
        input  req_ready, mul_A, mul_B, rsp_valid, rsp_id, rsp_M
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one combinational multi-limb multiplier among NUM_REQ clients;
// operands are held for MUL_LATENCY cycles before the product is captured and returned.
module mul_share_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_ELEMENTS = 17,
    parameter int BIT_LEN      = 17,
    parameter int MUL_LATENCY  = 2
) (
    input logic                clk,
    input logic                rst,
    mul_share_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                                 state;
    state_t                                 state_nx;
    logic [ID_W-1:0]                        rr_ptr;
    logic [ID_W-1:0]                        grant_idx;
    logic [ID_W-1:0]                        cand;
    logic                                   grant_any;
    logic                                   accept;
    logic                                   capture;
    logic [CNT_W-1:0]                       cnt;
    logic [NUM_REQ-1:0]                     req_ready_c;
    logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]   mul_a_q;
    logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]   mul_b_q;
    logic [2*NUM_ELEMENTS-1:0][BIT_LEN-1:0] rsp_m_q;
    logic [ID_W-1:0]                        rsp_id_q;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!grant_any && bus.req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready_c = '0;
        if (state == IDLE && grant_any) begin
            req_ready_c[grant_idx] = 1'b1;
        end
    end

    assign accept  = (state == IDLE) && grant_any;
    assign capture = (state == WAIT) && (cnt == '0);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept)        state_nx = WAIT;
            WAIT:    if (cnt == '0)     state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            cnt      <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            rsp_m_q  <= '0;
            rsp_id_q <= '0;
        end else begin
            if (accept) begin
                mul_a_q  <= bus.req_A[grant_idx];
                mul_b_q  <= bus.req_B[grant_idx];
                rsp_id_q <= grant_idx;
                rr_ptr   <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                cnt      <= CNT_W'(MUL_LATENCY - 1);
            end
            if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                rsp_m_q <= bus.mul_M;
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.mul_A     = mul_a_q;
    assign bus.mul_B     = mul_b_q;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_M     = rsp_m_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: a wide-integer multiplier drives mul_M from mul_A/mul_B,
// and each step checks grants, latency, hold behaviour and products against bench-side values.
module tb_mul_share_arbiter;
    localparam int NUM_REQ = 4;
    localparam int NE      = 17;
    localparam int BL      = 17;
    localparam int LAT     = 2;
    localparam int OW      = NE * BL;
    localparam int MW      = 2 * OW;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [OW-1:0] opA [NUM_REQ];
    logic [OW-1:0] opB [NUM_REQ];
    logic [OW-1:0] ma;
    logic [OW-1:0] mb;

    always #5 clk = ~clk;

    mul_share_arbiter_if #(.NUM_REQ(NUM_REQ), .NUM_ELEMENTS(NE), .BIT_LEN(BL)) bus ();

    mul_share_arbiter #(
        .NUM_REQ(NUM_REQ),
        .NUM_ELEMENTS(NE),
        .BIT_LEN(BL),
        .MUL_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Stand-in for the shared multiplier: limbs are plain radix-2^BL digits.
    assign ma        = bus.mul_A;
    assign mb        = bus.mul_B;
    assign bus.mul_M = {{OW{1'b0}}, ma} * {{OW{1'b0}}, mb};

    function automatic logic [MW-1:0] golden(input logic [OW-1:0] a, input logic [OW-1:0] b);
        return {{OW{1'b0}}, a} * {{OW{1'b0}}, b};
    endfunction

    task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic load_ops;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_A[i] = opA[i];
            bus.req_B[i] = opB[i];
        end
    endtask

    // Grant check in IDLE, accept edge, hold checks through WAIT, then response checks in RESP.
    task automatic run_op(input int g, input string tag);
        logic [NUM_REQ-1:0] onehot;
        onehot    = '0;
        onehot[g] = 1'b1;
        #1;
        chk({tag, " grant"}, bus.req_ready, onehot);
        tick;
        for (int w = 0; w < LAT; w++) begin
            chk({tag, " wait_rsp_valid"}, bus.rsp_valid, 0);
            chk({tag, " wait_req_ready"}, bus.req_ready, 0);
            chk({tag, " wait_mul_A"}, bus.mul_A, opA[g]);
            chk({tag, " wait_mul_B"}, bus.mul_B, opB[g]);
            tick;
        end
        chk({tag, " rsp_valid"}, bus.rsp_valid, 1);
        chk({tag, " rsp_id"}, bus.rsp_id, g);
        chk({tag, " rsp_M"}, bus.rsp_M, golden(opA[g], opB[g]));
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            opA[i] = '0;
            opB[i] = '0;
        end
        load_ops();
        tick;
        tick;
        chk("reset req_ready", bus.req_ready, 0);
        chk("reset rsp_valid", bus.rsp_valid, 0);
        chk("reset rsp_id", bus.rsp_id, 0);
        chk("reset mul_A", bus.mul_A, 0);
        chk("reset mul_B", bus.mul_B, 0);
        chk("reset rsp_M", bus.rsp_M, 0);
        rst = 1'b0;

        // Single op: 3 * 5 in limb 0.
        opA[0] = OW'(3);
        opB[0] = OW'(5);
        load_ops();
        bus.req_valid = 4'b0001;
        run_op(0, "single");
        chk("single rsp_M hand", bus.rsp_M, 15);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        tick;
        chk("single rsp_valid drop", bus.rsp_valid, 0);

        // Round-robin from a fresh pointer with every requester asking.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            opA[i] = OW'(i + 2);
            opB[i] = OW'(100 + i);
        end
        load_ops();
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            run_op(k % NUM_REQ, "rr");
            if (k == 4) bus.req_valid = '0;
            tick;
        end

        // Skip: advance pointer to 2, then 1001 must go 3 then 0.
        bus.req_valid = 4'b0010;
        run_op(1, "skip_setup");
        bus.req_valid = '0;
        tick;
        bus.req_valid = 4'b1001;
        run_op(3, "skip_first");
        tick;
        run_op(0, "skip_wrap");
        bus.req_valid = '0;
        tick;

        // Backpressure in RESP with all requesters asking.
        bus.rsp_ready = 1'b0;
        opA[2] = {NE{17'h0ABCD}};
        opB[2] = {NE{17'h00123}};
        load_ops();
        bus.req_valid = 4'b0100;
        run_op(2, "bp");
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp hold req_ready", bus.req_ready, 0);
            chk("bp hold rsp_valid", bus.rsp_valid, 1);
            chk("bp hold rsp_id", bus.rsp_id, 2);
            chk("bp hold rsp_M", bus.rsp_M, golden(opA[2], opB[2]));
            chk("bp hold mul_A", bus.mul_A, opA[2]);
            tick;
        end
        bus.rsp_ready = 1'b1;
        tick;
        #1;
        chk("bp next grant", bus.req_ready, 4'b1000);
        bus.req_valid = '0;

        // Reset while in WAIT: op is dropped and the pointer returns to 0.
        bus.req_valid = 4'b0001;
        #1;
        chk("rst_mid grant", bus.req_ready, 4'b0001);
        tick;
        bus.req_valid = '0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_mid rsp_valid", bus.rsp_valid, 0);
        chk("rst_mid mul_A", bus.mul_A, 0);
        bus.req_valid = 4'b1111;
        #1;
        chk("rst_mid rr_ptr", bus.req_ready, 4'b0001);
        bus.req_valid = '0;
        for (int c = 0; c < LAT + 2; c++) begin
            tick;
            chk("rst_mid no_rsp", bus.rsp_valid, 0);
        end

        // Full-scale operands: (2^289-1)^2 = 2^578 - 2^290 + 1.
        opA[1] = '1;
        opB[1] = '1;
        load_ops();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        run_op(1, "max");
        chk("max limb0", bus.rsp_M[0], 1);
        chk("max limb16", bus.rsp_M[16], 0);
        chk("max limb17", bus.rsp_M[17], 17'h1FFFE);
        chk("max limb33", bus.rsp_M[33], 17'h1FFFF);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        tick;
        chk("max rsp_valid drop", bus.rsp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
